multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter HAS_MULDIV, default 1, meaning: 1 adds the MULDIV wait state for M-extension OP instructions; 0 removes it.
REQ-002 Parameter MEM_TIMEOUT, default 0, meaning: cycles a memory wait may last before a bus-error trap; 0 disables the timeout.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 inst  in  32  current instruction.
REQ-006 interrupt_pending, exception_pending  in  1 each  trap requests.
REQ-007 mem_done  in  1  memory transaction complete.
REQ-008 muldiv_done  in  1  multiply/divide result valid.
REQ-009 trap_start, trap_finish  out  1 each  trap entry; MRET executed.
REQ-010 pc_write, reg_write, csr_write  out  1 each  architectural write enables.
REQ-011 mem_request  out  1  start a memory transaction.
REQ-012 mem_op  out  2  INST_READ / DATA_READ / DATA_WRITE.
REQ-013 muldiv_start  out  1  single-cycle start pulse for the mul/div unit.
REQ-014 bus_error  out  1  single-cycle pulse when a memory wait times out.
REQ-015 instret  out  1  single-cycle pulse per retired instruction.
REQ-016 wfi_sleep  out  1  high while in the WFI state.

Function
REQ-017 All outputs SHALL be combinational from state and inputs; defaults: all 0, mem_op=INST_READ.
REQ-018 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEMORY, WB, MULDIV and WFI.
REQ-019 FETCH: if interrupt_pending, assert pc_write+trap_start and stay in FETCH; otherwise assert mem_request and go to DECODE.
REQ-020 DECODE waits for mem_done. On mem_done with exception_pending it SHALL trap (pc_write+trap_start) and go to FETCH; otherwise it goes to EXECUTE.
REQ-021 EXECUTE, LUI/AUIPC/OP_IMM/JAL/JALR/OP (excluding M-ext when HAS_MULDIV=1): pc_write+reg_write, then FETCH.
REQ-022 EXECUTE, BRANCH/FENCE: pc_write, then FETCH.
REQ-023 EXECUTE, LOAD/STORE: mem_request, mem_op=DATA_READ/DATA_WRITE, then MEMORY.
REQ-024 EXECUTE, OP with funct7=0000001 and HAS_MULDIV=1: muldiv_start for exactly one cycle, then MULDIV.
REQ-025 MULDIV: hold until muldiv_done. On muldiv_done assert pc_write+reg_write, then FETCH.
REQ-026 EXECUTE, SYSTEM:
- func3!=0: pc_write+reg_write+csr_write, then FETCH.
- inst[31:20]=MRET: pc_write+trap_finish, then FETCH.
- inst[31:20]=WFI: pc_write, then WFI.
- other: pc_write, then FETCH.
REQ-027 WFI: wfi_sleep=1; exit to FETCH the cycle after interrupt_pending is sampled high.
REQ-028 MEMORY: hold mem_op until mem_done. A load then goes to WB; a store asserts pc_write and goes to FETCH.
REQ-029 WB: pc_write+reg_write, then FETCH.
REQ-030 A wait counter SHALL clear on entry to DECODE/MEMORY and increment each cycle mem_done is low there. It is ceil(log2(MEM_TIMEOUT+1)) bits wide, minimum 1.
REQ-031 If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with mem_done low: assert bus_error+pc_write+trap_start and go to FETCH.
REQ-032 mem_done in the timeout cycle SHALL win: normal completion, no bus_error.
REQ-033 instret SHALL pulse on every pc_write cycle without trap_start, including MRET and WFI entry; never on a trap.
REQ-034 An interrupt arriving outside FETCH/WFI SHALL be deferred to the next FETCH.

Reset
REQ-035 rst_n low SHALL force state FETCH and counter 0 immediately; outputs then follow FETCH decode (mem_request=1 unless interrupt_pending).
REQ-036 Reset mid-MEMORY/MULDIV/WFI SHALL abandon the operation without any output pulse after release beyond FETCH decode.

Structure
REQ-037 Opcodes, mem_op encodings, MRET/WFI funct12 values and the state enum SHALL live in the shared defs package.
REQ-038 The timeout counter SHALL be a sub-module, wait_timer (parameter MEM_TIMEOUT; inputs clear/enable; output expired).

Verification
REQ-039 ADDI, mem_done after 2 cycles -> FETCH,DECODE×3,EXECUTE; pc_write+reg_write+instret on cycle 5.
REQ-040 LW, MEM_TIMEOUT=0 -> MEMORY then WB; reg_write only in WB; exactly one instret.
REQ-041 MUL, HAS_MULDIV=1, muldiv_done 33 cycles after start -> one muldiv_start; reg_write in the done cycle; with HAS_MULDIV=0 it retires directly in EXECUTE.
REQ-042 SW, MEM_TIMEOUT=8, mem_done never -> bus_error+trap_start on the 8th MEMORY cycle, no instret; repeat with mem_done on that cycle -> no bus_error.
REQ-043 WFI, then interrupt_pending after 10 cycles -> wfi_sleep high for 10 cycles, FETCH, trap_start next cycle.
REQ-044 rst_n low mid-MULDIV -> FETCH asynchronously; no reg_write after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared definitions for the multicycle control FSM. Holds the
//               RV32 major opcodes, the funct7/funct12 codes the controller
//               decodes, the memory-operation encodings and the state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // RV32 major opcodes (inst[6:0])
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_fence  = 7'b0001111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  // funct7 selecting the M extension within OP
  localparam logic [6:0] c_f7_muldiv = 7'b0000001;

  // SYSTEM funct12 codes (inst[31:20])
  localparam logic [11:0] c_f12_mret = 12'h302;
  localparam logic [11:0] c_f12_wfi  = 12'h105;

  // mem_op encodings
  localparam logic [1:0] c_mem_inst_read  = 2'd0;
  localparam logic [1:0] c_mem_data_read  = 2'd1;
  localparam logic [1:0] c_mem_data_write = 2'd2;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEMORY  = 3'd3,
    WB      = 3'd4,
    MULDIV  = 3'd5,
    WFI     = 3'd6
  } state_e;

  // States in which the controller waits on mem_done and the timer runs.
  function automatic logic is_mem_wait(input state_e s);
    return (s == DECODE) || (s == MEMORY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Memory-wait cycle counter. Cleared on entry to a wait state,
//               counts each cycle the wait is still pending, and flags the
//               last permitted wait cycle.
// Ports       : clk, rst_n       - clock, async active-low reset
//               clear            - zero the count (wins over enable)
//               enable           - count this cycle
//               expired          - count has reached MEM_TIMEOUT-1
//                                  (never set when MEM_TIMEOUT == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (MEM_TIMEOUT > 0) begin : g_timeout
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MEM_TIMEOUT - 1);
    // The controller leaves the wait state in the expiry cycle, so the
    // counter never needs to saturate.
    assign expired = (cnt_q == c_last);
  end else begin : g_no_timeout
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
    assign expired    = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a multicycle RV32 core. Sequences fetch,
//               decode, execute, memory, write-back, mul/div wait and WFI
//               sleep, and raises trap entry on interrupts, exceptions and
//               memory-wait timeouts. All outputs are decoded combinationally
//               from the current state and the inputs.
// Ports       : clk, rst_n                         - clock, async active-low reset
//               inst[31:0]                         - current instruction
//               interrupt_pending/exception_pending- trap requests
//               mem_done, muldiv_done              - completion handshakes
//               trap_start, trap_finish            - trap entry / MRET
//               pc_write, reg_write, csr_write     - architectural writes
//               mem_request, mem_op[1:0]           - memory transaction
//               muldiv_start                       - mul/div start pulse
//               bus_error                          - memory wait timed out
//               instret                            - instruction retired
//               wfi_sleep                          - in WFI state
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int HAS_MULDIV  = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        interrupt_pending,
  input  logic        exception_pending,
  input  logic        mem_done,
  input  logic        muldiv_done,
  output logic        trap_start,
  output logic        trap_finish,
  output logic        pc_write,
  output logic        reg_write,
  output logic        csr_write,
  output logic        mem_request,
  output logic [1:0]  mem_op,
  output logic        muldiv_start,
  output logic        bus_error,
  output logic        instret,
  output logic        wfi_sleep
);

  state_e state_q, state_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] funct12;
  logic        is_muldiv_op;
  logic        in_mem_wait;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;
  logic        timed_out;
  logic        unused_inst;

  assign opcode       = inst[6:0];
  assign funct3       = inst[14:12];
  assign funct7       = inst[31:25];
  assign funct12      = inst[31:20];
  assign unused_inst  = ^{inst[19:15], inst[11:7]};
  assign is_muldiv_op = (HAS_MULDIV != 0) && (funct7 == c_f7_muldiv);

  // The timer restarts whenever a wait state is entered from elsewhere and
  // counts only cycles in which the transaction is still outstanding.
  assign in_mem_wait  = is_mem_wait(state_q);
  assign timer_clear  = is_mem_wait(state_d) && (state_d != state_q);
  assign timer_enable = in_mem_wait && !mem_done;
  // mem_done in the expiry cycle completes normally.
  assign timed_out    = in_mem_wait && timer_expired && !mem_done;

  wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    trap_start   = 1'b0;
    trap_finish  = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    csr_write    = 1'b0;
    mem_request  = 1'b0;
    mem_op       = c_mem_inst_read;
    muldiv_start = 1'b0;
    bus_error    = 1'b0;
    wfi_sleep    = 1'b0;
    instret      = 1'b0;

    case (state_q)
      FETCH: begin
        // Interrupts are only taken here (and to leave WFI); anything raised
        // in another state simply waits until the next fetch.
        if (interrupt_pending) begin
          pc_write   = 1'b1;
          trap_start = 1'b1;
        end else begin
          mem_request = 1'b1;
          state_d     = DECODE;
        end
      end

      DECODE: begin
        if (mem_done) begin
          if (exception_pending) begin
            pc_write   = 1'b1;
            trap_start = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = EXECUTE;
          end
        end else if (timed_out) begin
          bus_error  = 1'b1;
          pc_write   = 1'b1;
          trap_start = 1'b1;
          state_d    = FETCH;
        end
      end

      EXECUTE: begin
        state_d = FETCH;
        case (opcode)
          c_opc_lui, c_opc_auipc, c_opc_op_imm, c_opc_jal, c_opc_jalr: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          c_opc_op: begin
            if (is_muldiv_op) begin
              muldiv_start = 1'b1;
              state_d      = MULDIV;
            end else begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
            end
          end
          c_opc_branch, c_opc_fence: begin
            pc_write = 1'b1;
          end
          c_opc_load: begin
            mem_request = 1'b1;
            mem_op      = c_mem_data_read;
            state_d     = MEMORY;
          end
          c_opc_store: begin
            mem_request = 1'b1;
            mem_op      = c_mem_data_write;
            state_d     = MEMORY;
          end
          c_opc_system: begin
            pc_write = 1'b1;
            if (funct3 != 3'd0) begin
              reg_write = 1'b1;
              csr_write = 1'b1;
            end else if (funct12 == c_f12_mret) begin
              trap_finish = 1'b1;
            end else if (funct12 == c_f12_wfi) begin
              state_d = WFI;
            end
          end
          // Unrecognised opcodes advance the PC without side effects.
          default: begin
            pc_write = 1'b1;
          end
        endcase
      end

      MEMORY: begin
        // inst is held for the whole instruction, so the opcode still tells
        // a load from a store here.
        mem_op = (opcode == c_opc_store) ? c_mem_data_write : c_mem_data_read;
        if (mem_done) begin
          if (opcode == c_opc_store) begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timed_out) begin
          bus_error  = 1'b1;
          pc_write   = 1'b1;
          trap_start = 1'b1;
          state_d    = FETCH;
        end
      end

      WB: begin
        pc_write  = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end

      MULDIV: begin
        if (muldiv_done) begin
          pc_write  = 1'b1;
          reg_write = 1'b1;
          state_d   = FETCH;
        end
      end

      WFI: begin
        wfi_sleep = 1'b1;
        if (interrupt_pending) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Every PC update that is not a trap entry retires an instruction.
    instret = pc_write && !trap_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench. Two controllers are instantiated
//               (HAS_MULDIV=1/MEM_TIMEOUT=8 and HAS_MULDIV=0/MEM_TIMEOUT=0)
//               on shared inputs; each instruction is expanded by an
//               instruction-level model into a per-cycle list of stimulus and
//               expected outputs, which is then played against one DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  // Packed output vector:
  // {trap_start, trap_finish, pc_write, reg_write, csr_write, mem_request,
  //  muldiv_start, bus_error, instret, wfi_sleep, mem_op[1:0]}
  localparam logic [11:0] O_TS  = 12'h800;
  localparam logic [11:0] O_TF  = 12'h400;
  localparam logic [11:0] O_PC  = 12'h200;
  localparam logic [11:0] O_RW  = 12'h100;
  localparam logic [11:0] O_CSR = 12'h080;
  localparam logic [11:0] O_MR  = 12'h040;
  localparam logic [11:0] O_MDS = 12'h020;
  localparam logic [11:0] O_BE  = 12'h010;
  localparam logic [11:0] O_IR  = 12'h008;
  localparam logic [11:0] O_WFI = 12'h004;
  localparam logic [11:0] M_IRD = {10'd0, c_mem_inst_read};
  localparam logic [11:0] M_DRD = {10'd0, c_mem_data_read};
  localparam logic [11:0] M_DWR = {10'd0, c_mem_data_write};

  localparam int K_ALU = 0, K_BR = 1, K_LOAD = 2, K_STORE = 3, K_MUL = 4;
  localparam int K_CSR = 5, K_MRET = 6, K_WFI = 7, K_ECALL = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [11:0] exp;
    logic        md;
    logic        mdd;
    logic        irq;
    logic        exc;
  } step_t;

  logic        clk, rst_n;
  logic [31:0] inst;
  logic        interrupt_pending, exception_pending, mem_done, muldiv_done;

  logic a_ts, a_tf, a_pc, a_rw, a_csr, a_mr, a_mds, a_be, a_ir, a_wfi;
  logic b_ts, b_tf, b_pc, b_rw, b_csr, b_mr, b_mds, b_be, b_ir, b_wfi;
  logic [1:0]  a_mop, b_mop;
  logic [11:0] a_vec, b_vec;

  int    checks   = 0;
  int    failures = 0;
  step_t plan_q[$];
  logic [31:0] cur_inst;
  bit    pending_irq;
  string cur_name;

  multicycle_ctrl #(.HAS_MULDIV(1), .MEM_TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .interrupt_pending(interrupt_pending), .exception_pending(exception_pending),
    .mem_done(mem_done), .muldiv_done(muldiv_done),
    .trap_start(a_ts), .trap_finish(a_tf), .pc_write(a_pc), .reg_write(a_rw),
    .csr_write(a_csr), .mem_request(a_mr), .mem_op(a_mop), .muldiv_start(a_mds),
    .bus_error(a_be), .instret(a_ir), .wfi_sleep(a_wfi)
  );

  multicycle_ctrl #(.HAS_MULDIV(0), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .interrupt_pending(interrupt_pending), .exception_pending(exception_pending),
    .mem_done(mem_done), .muldiv_done(muldiv_done),
    .trap_start(b_ts), .trap_finish(b_tf), .pc_write(b_pc), .reg_write(b_rw),
    .csr_write(b_csr), .mem_request(b_mr), .mem_op(b_mop), .muldiv_start(b_mds),
    .bus_error(b_be), .instret(b_ir), .wfi_sleep(b_wfi)
  );

  assign a_vec = {a_ts, a_tf, a_pc, a_rw, a_csr, a_mr, a_mds, a_be, a_ir, a_wfi, a_mop};
  assign b_vec = {b_ts, b_tf, b_pc, b_rw, b_csr, b_mr, b_mds, b_be, b_ir, b_wfi, b_mop};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [11:0] got, input logic [11:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%03h expected=%03h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [11:0] e, input logic md, input logic mdd,
                      input logic irq, input logic exc);
    step_t s;
    s.inst = cur_inst; s.exp = e; s.md = md; s.mdd = mdd; s.irq = irq; s.exc = exc;
    plan_q.push_back(s);
  endtask

  // Memory wait: lat cycles without mem_done. With a timeout configured, the
  // tmo-th outstanding cycle is a bus-error trap instead.
  task automatic wait_phase(input int lat, input int tmo, input logic [11:0] mop,
                            input logic bi, output bit to);
    to = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (tmo > 0 && i == tmo - 1) begin
        push(O_TS | O_PC | O_BE | mop, 1'b0, 1'b0, bi, 1'b0);
        to = 1'b1;
        return;
      end
      push(mop, 1'b0, 1'b0, bi, 1'b0);
    end
  endtask

  function automatic logic [31:0] make_inst(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      K_ALU: begin
        case ($urandom_range(0, 5))
          0: r[6:0] = 7'b0110111;
          1: r[6:0] = 7'b0010111;
          2: r[6:0] = 7'b0010011;
          3: r[6:0] = 7'b1101111;
          4: r[6:0] = 7'b1100111;
          default: begin
            r[6:0]   = 7'b0110011;
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
          end
        endcase
      end
      K_BR:    r[6:0] = ($urandom_range(0, 1) != 0) ? 7'b1100011 : 7'b0001111;
      K_LOAD:  r[6:0] = 7'b0000011;
      K_STORE: r[6:0] = 7'b0100011;
      K_MUL: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000001; end
      K_CSR: begin r[6:0] = 7'b1110011; r[14:12] = 3'($urandom_range(1, 7)); end
      K_MRET: begin r[6:0] = 7'b1110011; r[14:12] = 3'd0; r[31:20] = 12'h302; end
      K_WFI:  begin r[6:0] = 7'b1110011; r[14:12] = 3'd0; r[31:20] = 12'h105; end
      default: begin
        r[6:0] = 7'b1110011; r[14:12] = 3'd0;
        r[31:20] = ($urandom_range(0, 1) != 0) ? 12'h001 : 12'h000;
      end
    endcase
    return r;
  endfunction

  // Instruction-level model: fl = fetch wait cycles, ml = memory or mul/div
  // wait cycles, wl = WFI cycles before the interrupt, exc = fetch faults,
  // bi = an interrupt is held high from decode onwards (taken next fetch).
  task automatic plan_instr(input int kind, input int sel, input int fl, input int ml,
                            input int wl, input bit exc, input bit bi_in);
    int  tmo;
    bit  has_md, to;
    logic bi;
    tmo    = (sel == 0) ? 8 : 0;
    has_md = (sel == 0);
    bi     = (kind == K_WFI) ? 1'b0 : bi_in;
    cur_inst = make_inst(kind);
    if (pending_irq) push(O_TS | O_PC, 1'b0, 1'b0, 1'b1, 1'b0);
    pending_irq = bi;
    push(O_MR | M_IRD, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_phase(fl, tmo, M_IRD, bi, to);
    if (to) return;
    if (exc) begin
      push(O_TS | O_PC, 1'b1, 1'b0, bi, 1'b1);
      return;
    end
    push(12'h000, 1'b1, 1'b0, bi, 1'b0);
    case (kind)
      K_ALU:          push(O_PC | O_RW | O_IR, 1'b0, 1'b0, bi, 1'b0);
      K_BR, K_ECALL:  push(O_PC | O_IR, 1'b0, 1'b0, bi, 1'b0);
      K_CSR:          push(O_PC | O_RW | O_CSR | O_IR, 1'b0, 1'b0, bi, 1'b0);
      K_MRET:         push(O_PC | O_TF | O_IR, 1'b0, 1'b0, bi, 1'b0);
      K_MUL: begin
        if (has_md) begin
          push(O_MDS, 1'b0, 1'b0, bi, 1'b0);
          for (int i = 0; i < ml; i++) push(12'h000, 1'b0, 1'b0, bi, 1'b0);
          push(O_PC | O_RW | O_IR, 1'b0, 1'b1, bi, 1'b0);
        end else begin
          push(O_PC | O_RW | O_IR, 1'b0, 1'b0, bi, 1'b0);
        end
      end
      K_LOAD: begin
        push(O_MR | M_DRD, 1'b0, 1'b0, bi, 1'b0);
        wait_phase(ml, tmo, M_DRD, bi, to);
        if (!to) begin
          push(M_DRD, 1'b1, 1'b0, bi, 1'b0);
          push(O_PC | O_RW | O_IR, 1'b0, 1'b0, bi, 1'b0);
        end
      end
      K_STORE: begin
        push(O_MR | M_DWR, 1'b0, 1'b0, bi, 1'b0);
        wait_phase(ml, tmo, M_DWR, bi, to);
        if (!to) push(M_DWR | O_PC | O_IR, 1'b1, 1'b0, bi, 1'b0);
      end
      default: begin // WFI
        push(O_PC | O_IR, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < wl; i++) push(O_WFI, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_WFI, 1'b0, 1'b0, 1'b1, 1'b0);
        push(O_TS | O_PC, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    endcase
  endtask

  // Plays at most n queued cycles (n < 0: all) against the selected DUT.
  task automatic run_plan(input int sel, input int n);
    step_t s;
    int k;
    k = 0;
    while (plan_q.size() > 0 && (n < 0 || k < n)) begin
      s = plan_q.pop_front();
      @(negedge clk);
      inst = s.inst; mem_done = s.md; muldiv_done = s.mdd;
      interrupt_pending = s.irq; exception_pending = s.exc;
      #1;
      check((sel == 0) ? a_vec : b_vec, s.exp, $sformatf("%s#%0d", cur_name, k));
      k++;
    end
    plan_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mem_done = 1'b0; muldiv_done = 1'b0; exception_pending = 1'b0;
    interrupt_pending = 1'b1;
    #1;
    check(a_vec, O_TS | O_PC, "reset_irq_a");
    check(b_vec, O_TS | O_PC, "reset_irq_b");
    interrupt_pending = 1'b0;
    #1;
    check(a_vec, O_MR | M_IRD, "reset_a");
    check(b_vec, O_MR | M_IRD, "reset_b");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    pending_irq = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inst = '0; interrupt_pending = 1'b0; exception_pending = 1'b0;
    mem_done = 1'b0; muldiv_done = 1'b0; pending_irq = 1'b0; cur_inst = '0;
    repeat (3) @(posedge clk);

    // ADDI, two fetch wait cycles: retire on the fifth cycle
    do_reset();
    cur_name = "addi";
    plan_instr(K_ALU, 0, 2, 0, 0, 1'b0, 1'b0);
    plan_q[0].inst[6:0] = 7'b0010011;
    for (int i = 1; i < plan_q.size(); i++) plan_q[i].inst = plan_q[0].inst;
    run_plan(0, -1);

    // LW without timeout
    do_reset();
    cur_name = "lw";
    plan_instr(K_LOAD, 1, 1, 3, 0, 1'b0, 1'b0);
    run_plan(1, -1);

    // MUL with and without the mul/div unit
    cur_name = "mul_md";
    do_reset();
    plan_instr(K_MUL, 0, 1, 32, 0, 1'b0, 1'b0);
    run_plan(0, -1);
    cur_name = "mul_nomd";
    do_reset();
    plan_instr(K_MUL, 1, 1, 32, 0, 1'b0, 1'b0);
    run_plan(1, -1);

    // SW timeout, then mem_done exactly in the last permitted cycle
    do_reset();
    cur_name = "sw_timeout";
    plan_instr(K_STORE, 0, 0, 100, 0, 1'b0, 1'b0);
    run_plan(0, -1);
    cur_name = "sw_edge";
    plan_instr(K_STORE, 0, 0, 7, 0, 1'b0, 1'b0);
    run_plan(0, -1);
    cur_name = "fetch_timeout";
    plan_instr(K_ALU, 0, 20, 0, 0, 1'b0, 1'b0);
    run_plan(0, -1);

    // WFI: ten sleep cycles, then trap in FETCH
    cur_name = "wfi";
    plan_instr(K_WFI, 0, 1, 0, 9, 1'b0, 1'b0);
    run_plan(0, -1);

    // Interrupt raised mid-instruction is deferred; fetch exception traps
    cur_name = "irq_defer";
    plan_instr(K_LOAD, 0, 1, 2, 0, 1'b0, 1'b1);
    run_plan(0, -1);
    cur_name = "exc";
    plan_instr(K_ALU, 0, 1, 0, 0, 1'b1, 1'b0);
    run_plan(0, -1);

    // Every instruction class once on the no-muldiv configuration
    do_reset();
    for (int k = 0; k <= K_ECALL; k++) begin
      cur_name = $sformatf("kind%0d", k);
      plan_instr(k, 1, 1, 2, 1, 1'b0, 1'b0);
      run_plan(1, -1);
    end

    // Reset mid-MULDIV: FETCH immediately, no write after release
    do_reset();
    cur_name = "mul_rst";
    plan_instr(K_MUL, 0, 1, 32, 0, 1'b0, 1'b0);
    run_plan(0, 6);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(a_vec, O_MR | M_IRD, "mul_rst_async");
    muldiv_done = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cur_name = "mul_rst_post";
    cur_inst = inst;
    push(O_MR | M_IRD, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_plan(0, -1);

    // Randomised instruction streams on both configurations
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      for (int n = 0; n < 60; n++) begin
        int kind;
        kind = $urandom_range(0, 8);
        cur_name = $sformatf("rnd%0d_%0d_k%0d", sel, n, kind);
        plan_instr(kind, sel,
                   $urandom_range(0, (sel == 0) ? 10 : 4),
                   (kind == K_MUL) ? $urandom_range(0, 6) : $urandom_range(0, (sel == 0) ? 10 : 4),
                   $urandom_range(0, 4),
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 5) == 0);
        run_plan(sel, -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
